// File: rtl/alu_result_fifo.sv
// ALU result/flag FIFO with sticky overflow and saturating overflow counter; 1-cycle push-to-head latency, no bypass.
// Backpressure: in_ready drops while full (a same-cycle pop does not free a slot); head data holds while out_ready=0.

module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_vld,
  output logic                       wr_rdy,
  input  logic [W-1:0]               wr_dat,
  output logic                       rd_vld,
  input  logic                       rd_rdy,
  output logic [W-1:0]               rd_dat,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt;
  logic          push, pop;

  // Ready/valid come only from registered occupancy, so full blocks a push even when a pop happens.
  assign wr_rdy = (cnt != FULL_CNT) & ~rst;
  assign rd_vld = (cnt != '0) & ~rst;
  assign push   = wr_vld & wr_rdy;
  assign pop    = rd_vld & rd_rdy;
  assign rd_dat = rd_vld ? mem[rd_ptr] : '0;
  assign count  = cnt;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      cnt <= cnt + 1'b1;
      else if (pop && !push) cnt <= cnt - 1'b1;
    end
  end
endmodule

module alu_result_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_result,
  input  logic                     in_zero,
  input  logic                     in_cout,
  input  logic                     in_overflow,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_result,
  output logic                     out_zero,
  output logic                     out_cout,
  output logic                     out_overflow,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     sticky_ovf,
  output logic [CNT_W-1:0]         ovf_cnt,
  input  logic                     clr_status
);
  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             cout;
    logic             overflow;
  } entry_t;

  entry_t wr_entry, rd_entry;
  logic   ovf_push;

  assign wr_entry = '{result: in_result, zero: in_zero, cout: in_cout, overflow: in_overflow};

  sync_fifo #(.W($bits(entry_t)), .DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_vld (in_valid),
    .wr_rdy (in_ready),
    .wr_dat (wr_entry),
    .rd_vld (out_valid),
    .rd_rdy (out_ready),
    .rd_dat (rd_entry),
    .count  (count)
  );

  assign out_result   = rd_entry.result;
  assign out_zero     = rd_entry.zero;
  assign out_cout     = rd_entry.cout;
  assign out_overflow = rd_entry.overflow;

  assign ovf_push = in_valid & in_ready & in_overflow;

  // An overflow push in the same cycle as a clear restarts the count at one.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_ovf <= 1'b0;
      ovf_cnt    <= '0;
    end else if (ovf_push) begin
      sticky_ovf <= 1'b1;
      if (clr_status)           ovf_cnt <= CNT_W'(1);
      else if (ovf_cnt != '1)   ovf_cnt <= ovf_cnt + 1'b1;
    end else if (clr_status) begin
      sticky_ovf <= 1'b0;
      ovf_cnt    <= '0;
    end
  end
endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed bench for alu_result_fifo: reset, single word, fill/wrap, streaming, status, mid-op reset.
module tb_alu_result_fifo;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] in_result;
  logic        in_zero, in_cout, in_overflow;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic        out_zero, out_cout, out_overflow;
  logic [2:0]  count;
  logic        sticky_ovf;
  logic [7:0]  ovf_cnt;
  logic        clr_status;

  int total = 0;
  int bad   = 0;

  alu_result_fifo #(.WIDTH(32), .DEPTH(4), .CNT_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_result    (in_result),
    .in_zero      (in_zero),
    .in_cout      (in_cout),
    .in_overflow  (in_overflow),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_zero     (out_zero),
    .out_cout     (out_cout),
    .out_overflow (out_overflow),
    .count        (count),
    .sticky_ovf   (sticky_ovf),
    .ovf_cnt      (ovf_cnt),
    .clr_status   (clr_status)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_result = '0; in_zero = 1'b0; in_cout = 1'b0;
    in_overflow = 1'b0; out_ready = 1'b0; clr_status = 1'b0;
    tick(); tick();
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    rst = 1'b0;
    tick();
    chk("idle_count", 64'(count), 64'(0));
    chk("idle_out_valid", 64'(out_valid), 64'(0));
    chk("idle_out_result", 64'(out_result), 64'(0));
    chk("idle_in_ready", 64'(in_ready), 64'(1));
    chk("idle_sticky", 64'(sticky_ovf), 64'(0));
    chk("idle_ovf_cnt", 64'(ovf_cnt), 64'(0));

    // single word
    in_valid = 1'b1; in_result = 32'hDEADBEEF; in_zero = 1'b0; in_cout = 1'b1; in_overflow = 1'b0;
    chk("no_bypass", 64'(out_valid), 64'(0));
    tick();
    in_valid = 1'b0; in_cout = 1'b0;
    chk("single_valid", 64'(out_valid), 64'(1));
    chk("single_result", 64'(out_result), 64'h0000_0000_DEAD_BEEF);
    chk("single_cout", 64'(out_cout), 64'(1));
    chk("single_zero", 64'(out_zero), 64'(0));
    chk("single_count", 64'(count), 64'(1));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("single_pop_count", 64'(count), 64'(0));
    chk("single_pop_valid", 64'(out_valid), 64'(0));

    // fill and wrap
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_result = 32'(i);
      tick();
    end
    in_valid = 1'b0;
    chk("full_count", 64'(count), 64'(4));
    chk("full_in_ready", 64'(in_ready), 64'(0));
    chk("full_head", 64'(out_result), 64'(1));
    in_valid = 1'b1; in_result = 32'd5; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("full_pop_count", 64'(count), 64'(3));
    chk("full_pop_in_ready", 64'(in_ready), 64'(1));
    chk("full_pop_head", 64'(out_result), 64'(2));
    tick();
    in_valid = 1'b0;
    chk("refill_count", 64'(count), 64'(4));
    for (int e = 2; e <= 5; e++) begin
      chk("wrap_valid", 64'(out_valid), 64'(1));
      chk("wrap_order", 64'(out_result), 64'(e));
      out_ready = 1'b1;
      tick();
    end
    out_ready = 1'b0;
    chk("wrap_empty", 64'(count), 64'(0));

    // streaming
    in_valid = 1'b1; out_ready = 1'b1; in_zero = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_result = 32'(100 + i);
      tick();
      chk("stream_count", 64'(count), 64'(1));
      chk("stream_data", 64'(out_result), 64'(100 + i));
      chk("stream_zero", 64'(out_zero), 64'(1));
    end
    in_valid = 1'b0; in_zero = 1'b0;
    tick();
    out_ready = 1'b0;
    chk("stream_drain", 64'(count), 64'(0));

    // status
    in_valid = 1'b1; in_overflow = 1'b1; out_ready = 1'b1;
    repeat (3) tick();
    in_valid = 1'b0; in_overflow = 1'b0;
    tick();
    chk("ovf3_sticky", 64'(sticky_ovf), 64'(1));
    chk("ovf3_cnt", 64'(ovf_cnt), 64'(3));
    in_valid = 1'b1; in_overflow = 1'b1; clr_status = 1'b1;
    tick();
    chk("clr_push_head_ovf", 64'(out_overflow), 64'(1));
    in_valid = 1'b0; in_overflow = 1'b0; clr_status = 1'b0;
    chk("clr_push_cnt", 64'(ovf_cnt), 64'(1));
    chk("clr_push_sticky", 64'(sticky_ovf), 64'(1));
    tick();
    chk("pop_keeps_cnt", 64'(ovf_cnt), 64'(1));
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    chk("clr_cnt", 64'(ovf_cnt), 64'(0));
    chk("clr_sticky", 64'(sticky_ovf), 64'(0));
    in_valid = 1'b1; in_overflow = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (i == 254) chk("sat_254", 64'(ovf_cnt), 64'(254));
      if (i == 255) chk("sat_255", 64'(ovf_cnt), 64'(255));
    end
    in_valid = 1'b0; in_overflow = 1'b0;
    tick();
    out_ready = 1'b0;
    chk("sat_300", 64'(ovf_cnt), 64'(255));
    chk("sat_sticky", 64'(sticky_ovf), 64'(1));

    // mid-operation reset
    in_valid = 1'b1;
    in_result = 32'hAA; tick();
    in_result = 32'hBB; tick();
    in_result = 32'hCC; tick();
    in_valid = 1'b0;
    chk("pre_rst_count", 64'(count), 64'(3));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_count", 64'(count), 64'(0));
    chk("mid_rst_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_result", 64'(out_result), 64'(0));
    chk("mid_rst_ovf_cnt", 64'(ovf_cnt), 64'(0));
    chk("mid_rst_sticky", 64'(sticky_ovf), 64'(0));
    in_valid = 1'b1; in_result = 32'hEE;
    tick();
    in_valid = 1'b0;
    chk("post_rst_head", 64'(out_result), 64'hEE);
    chk("post_rst_count", 64'(count), 64'(1));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("post_rst_empty", 64'(out_valid), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
